// File: rtl/wishbone_peripheral_bridge.sv
// Wishbone classic slave that drives the shared we/oe/address/tristate-data peripheral bus.
// Partial-word writes run as read-modify-write; a per-phase busy timeout bounds every access.
module wishbone_peripheral_bridge #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    output logic [31:0] peripheralBus_address,
    inout  wire  [31:0] peripheralBus_data,
    input  logic        peripheralBus_busy,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q;
    logic        ack_q;
    logic        we_q;
    logic        oe_q;
    logic        rmw_q;
    logic [3:0]  sel_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] merged_d;
    logic        req_hit;

    // A request is cyc & stb with a matching page; the master holds it until it sees the
    // one-cycle ack, and the bridge only samples it in IDLE, so it is taken exactly once.
    assign req_hit = wb_cyc_i && wb_stb_i && (wb_adr_i[31:24] == BASE_ADDRESS[31:24]);

    // Selected bytes come from the master, the rest from the word just read back.
    always_comb begin
        merged_d = peripheralBus_data;
        for (int b = 0; b < 4; b++) begin
            if (sel_q[b]) merged_d[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            rmw_q   <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_hit) begin
                        addr_q  <= {8'h00, wb_adr_i[23:0]};
                        wdata_q <= wb_dat_i;
                        sel_q   <= wb_sel_i;
                        cnt_q   <= '0;
                        rmw_q   <= 1'b0;
                        if (!wb_we_i) begin
                            state_q <= S_READ;
                            oe_q    <= 1'b1;
                        end else if (wb_sel_i == 4'hF) begin
                            state_q <= S_WRITE;
                            we_q    <= 1'b1;
                        end else if (wb_sel_i == 4'h0) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            oe_q    <= 1'b1;
                            rmw_q   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (!peripheralBus_busy) begin
                        oe_q  <= 1'b0;
                        cnt_q <= '0;
                        if (rmw_q) begin
                            wdata_q <= merged_d;
                            we_q    <= 1'b1;
                            state_q <= S_WRITE;
                        end else begin
                            rdata_q <= peripheralBus_data;
                            ack_q   <= 1'b1;
                            state_q <= S_ACK;
                        end
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        // Aborted read: report all-ones and never issue the RMW write.
                        oe_q    <= 1'b0;
                        rdata_q <= 32'hFFFF_FFFF;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WRITE: begin
                    if (!peripheralBus_busy || cnt_q == TIMEOUT_CNT) begin
                        we_q    <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o              = ack_q;
    assign wb_dat_o              = rdata_q;
    assign peripheralBus_we      = we_q;
    assign peripheralBus_oe      = oe_q;
    assign peripheralBus_address = addr_q;
    assign peripheralBus_data    = we_q ? wdata_q : 32'bz;
    assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_wishbone_peripheral_bridge.sv
// Bench for wishbone_peripheral_bridge: vector table, corner sequences, random traffic vs a model.
module tb_wishbone_peripheral_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        pbus_we;
    logic        pbus_oe;
    logic [31:0] pbus_addr;
    wire  [31:0] pbus;
    logic        pbus_busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Peripheral register file and bus monitor totals
    logic [31:0] pmem [64] = '{default: '0};
    int          we_tot = 0;
    int          oe_tot = 0;
    int          bad_tot = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] mon_addr = '0;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          stall;
        int          exp_lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_we;
        int          exp_oe;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [15];

    // Clock and DUT
    always #5 clk = ~clk;

    wishbone_peripheral_bridge #(
        .BASE_ADDRESS (32'h3000_0000),
        .TIMEOUT      (TO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .wb_cyc_i              (wb_cyc_i),
        .wb_stb_i              (wb_stb_i),
        .wb_we_i               (wb_we_i),
        .wb_sel_i              (wb_sel_i),
        .wb_adr_i              (wb_adr_i),
        .wb_dat_i              (wb_dat_i),
        .wb_ack_o              (wb_ack_o),
        .wb_dat_o              (wb_dat_o),
        .peripheralBus_we      (pbus_we),
        .peripheralBus_oe      (pbus_oe),
        .peripheralBus_address (pbus_addr),
        .peripheralBus_data    (pbus),
        .peripheralBus_busy    (pbus_busy),
        .dbg_state_o           (dbg_state)
    );

    assign pbus = pbus_oe ? pmem[pbus_addr[7:2]] : 32'bz;

    always @(posedge clk) begin
        if (pbus_we && !pbus_busy) pmem[pbus_addr[7:2]] <= pbus;
    end

    always @(negedge clk) begin
        if (pbus_we) begin
            we_tot     = we_tot + 1;
            last_wdata = pbus;
        end
        if (pbus_oe) oe_tot = oe_tot + 1;
        if (pbus_we && pbus_oe) bad_tot = bad_tot + 1;
        if ((pbus_we || pbus_oe) && pbus_addr != mon_addr) bad_tot = bad_tot + 1;
    end

    // Scoreboard helper
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: one Wishbone access; stall holds busy high for the first cycles of the first phase.
    task automatic wb_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int stall, input logic drop,
                          output int lat, output logic [31:0] rd, output int n_we,
                          output int n_oe, output int n_bad, output logic [31:0] wd);
        int we0;
        int oe0;
        int bad0;
        we0      = we_tot;
        oe0      = oe_tot;
        bad0     = bad_tot;
        mon_addr = {8'h00, adr[23:0]};
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_adr_i = adr;
        wb_dat_i = dat;
        lat      = -1;
        rd       = '0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            pbus_busy = (c <= stall);
            if (drop) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            @(negedge clk);
            if (wb_ack_o) begin
                lat = c;
                rd  = wb_dat_o;
            end
        end
        @(posedge clk);
        #1;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        pbus_busy = 1'b0;
        n_we  = we_tot - we0;
        n_oe  = oe_tot - oe0;
        n_bad = bad_tot - bad0;
        wd    = last_wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n_we;
        int          n_oe;
        int          n_bad;
        int          acks;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] ref_mem [4];
        logic [31:0] exp_dat;
        logic [31:0] mask;
        logic        r_we;
        logic        r_match;
        logic [3:0]  r_sel;
        logic [31:0] r_adr;
        logic [31:0] r_dat;
        logic [7:0]  r_top;
        int          r_idx;
        int          r_stall;
        int          e_lat;
        int          e_we;
        int          e_oe;
        logic [31:0] e_rd;
        logic [31:0] e_wd;

        vecs[0]  = '{1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 0,  2,  1'b0, 32'h0,         1, 0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,         0,  2,  1'b1, 32'hDEAD_BEEF, 0, 1, 32'h0};
        vecs[2]  = '{1'b1, 4'hF, 32'h3000_0020, 32'h1122_3344, 0,  2,  1'b0, 32'h0,         1, 0, 32'h1122_3344};
        vecs[3]  = '{1'b1, 4'h5, 32'h3000_0020, 32'hAABB_CCDD, 0,  3,  1'b0, 32'h0,         1, 1, 32'h11BB_33DD};
        vecs[4]  = '{1'b0, 4'hF, 32'h3000_0020, 32'h0,         3,  5,  1'b1, 32'h11BB_33DD, 0, 4, 32'h0};
        vecs[5]  = '{1'b0, 4'hF, 32'h3000_0020, 32'h0,         99, 6,  1'b1, 32'hFFFF_FFFF, 0, 5, 32'h0};
        vecs[6]  = '{1'b1, 4'h3, 32'h3000_0020, 32'h1234_5678, 99, 6,  1'b1, 32'hFFFF_FFFF, 0, 5, 32'h0};
        vecs[7]  = '{1'b0, 4'hF, 32'h3000_0020, 32'h0,         0,  2,  1'b1, 32'h11BB_33DD, 0, 1, 32'h0};
        vecs[8]  = '{1'b0, 4'hF, 32'h4000_0000, 32'h0,         0,  -1, 1'b0, 32'h0,         0, 0, 32'h0};
        vecs[9]  = '{1'b1, 4'hF, 32'h4000_0000, 32'h5555_AAAA, 0,  -1, 1'b0, 32'h0,         0, 0, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 32'h3000_0020, 32'hCAFE_F00D, 0,  1,  1'b1, 32'h11BB_33DD, 0, 0, 32'h0};
        vecs[11] = '{1'b1, 4'hF, 32'h3000_0030, 32'h0BAD_F00D, 2,  4,  1'b0, 32'h0,         3, 0, 32'h0BAD_F00D};
        vecs[12] = '{1'b0, 4'hF, 32'h3000_0030, 32'h0,         0,  2,  1'b1, 32'h0BAD_F00D, 0, 1, 32'h0};
        vecs[13] = '{1'b1, 4'hF, 32'h3000_0040, 32'h7777_7777, 99, 6,  1'b0, 32'h0,         5, 0, 32'h7777_7777};
        vecs[14] = '{1'b0, 4'hF, 32'h3000_0040, 32'h0,         0,  2,  1'b1, 32'h0000_0000, 0, 1, 32'h0};

        // Reset block
        rst       = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_sel_i  = '0;
        wb_adr_i  = '0;
        wb_dat_i  = '0;
        pbus_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ack", 32'(wb_ack_o), 32'd0);
        check("reset dat_o", wb_dat_o, 32'h0);
        check("reset we", 32'(pbus_we), 32'd0);
        check("reset oe", 32'(pbus_oe), 32'd0);
        check("reset address", pbus_addr, 32'h0);
        check("reset state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            wb_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].stall, 1'b0,
                   lat, rd, n_we, n_oe, n_bad, wd);
            check($sformatf("v%0d ack latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d we cycles", i), 32'(n_we), 32'(vecs[i].exp_we));
            check($sformatf("v%0d oe cycles", i), 32'(n_oe), 32'(vecs[i].exp_oe));
            check($sformatf("v%0d bus invariants", i), 32'(n_bad), 32'd0);
            if (vecs[i].chk_rd) check($sformatf("v%0d dat_o", i), rd, vecs[i].exp_rd);
            if (vecs[i].exp_we > 0) check($sformatf("v%0d write data", i), wd, vecs[i].exp_wd);
            if (vecs[i].exp_lat >= 0)
                check($sformatf("v%0d address", i), pbus_addr, {8'h00, vecs[i].adr[23:0]});
        end

        // Reset asserted while a write is on the bus
        mon_addr = 32'h0000_0080;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_sel_i = 4'hF;
        wb_adr_i = 32'h3000_0080;
        wb_dat_i = 32'h5A5A_A5A5;
        @(posedge clk);
        #1;
        pbus_busy = 1'b1;
        @(negedge clk);
        check("mid-write we before reset", 32'(pbus_we), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async reset we", 32'(pbus_we), 32'd0);
        check("async reset oe", 32'(pbus_oe), 32'd0);
        check("async reset ack", 32'(wb_ack_o), 32'd0);
        check("async reset state", 32'(dbg_state), 32'd0);
        check("async reset address", pbus_addr, 32'h0);
        check("async reset dat_o", wb_dat_o, 32'h0);
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        pbus_busy = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        check("no ack after reset", 32'(acks), 32'd0);
        @(posedge clk);
        #1;

        // cyc/stb dropped right after acceptance: the RMW still completes and acks
        wb_txn(1'b1, 4'b0001, 32'h3000_00A0, 32'h1234_5655, 0, 1'b1, lat, rd, n_we, n_oe, n_bad, wd);
        check("drop ack latency", 32'(lat), 32'd3);
        check("drop write data", wd, 32'h0000_0055);
        check("drop oe cycles", 32'(n_oe), 32'd1);
        check("drop dat_o held", rd, 32'h0);
        wb_txn(1'b0, 4'hF, 32'h3000_00A0, 32'h0, 0, 1'b0, lat, rd, n_we, n_oe, n_bad, wd);
        check("drop readback", rd, 32'h0000_0055);

        // Random traffic against the reference model
        ref_mem = '{default: '0};
        exp_dat = 32'h0000_0055;
        for (int t = 0; t < 60; t++) begin
            r_match = ($urandom_range(0, 9) != 0);
            r_idx   = $urandom_range(0, 3);
            r_we    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       r_sel = 4'hF;
                1:       r_sel = 4'h0;
                default: r_sel = 4'($urandom_range(1, 14));
            endcase
            r_dat   = $urandom;
            r_stall = $urandom_range(0, TO - 1);
            r_top   = 8'($urandom_range(0, 255));
            if (r_top == 8'h30) r_top = 8'h31;
            r_adr = r_match ? (32'h3000_0000 | 32'(r_idx * 4)) : {r_top, 24'($urandom)};

            e_lat = -1;
            e_we  = 0;
            e_oe  = 0;
            e_wd  = '0;
            if (r_match) begin
                if (!r_we) begin
                    exp_dat = ref_mem[r_idx];
                    e_lat   = 2 + r_stall;
                    e_oe    = 1 + r_stall;
                end else if (r_sel == 4'h0) begin
                    e_lat = 1;
                end else begin
                    mask = '0;
                    for (int b = 0; b < 4; b++) if (r_sel[b]) mask[8*b +: 8] = 8'hFF;
                    e_wd = (ref_mem[r_idx] & ~mask) | (r_dat & mask);
                    ref_mem[r_idx] = e_wd;
                    if (r_sel == 4'hF) begin
                        e_lat = 2 + r_stall;
                        e_we  = 1 + r_stall;
                    end else begin
                        e_lat = 3 + r_stall;
                        e_oe  = 1 + r_stall;
                        e_we  = 1;
                    end
                end
            end
            e_rd = exp_dat;

            wb_txn(r_we, r_sel, r_adr, r_dat, r_stall, 1'b0, lat, rd, n_we, n_oe, n_bad, wd);
            check($sformatf("r%0d ack latency", t), 32'(lat), 32'(e_lat));
            check($sformatf("r%0d we cycles", t), 32'(n_we), 32'(e_we));
            check($sformatf("r%0d oe cycles", t), 32'(n_oe), 32'(e_oe));
            check($sformatf("r%0d bus invariants", t), 32'(n_bad), 32'd0);
            if (e_lat >= 0) check($sformatf("r%0d dat_o", t), rd, e_rd);
            if (e_we > 0) check($sformatf("r%0d write data", t), wd, e_wd);
        end

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
